i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) port for the RTC subsystem that exposes an internal byte-wide register file to an external I2C controller. It decodes START/STOP/repeated START, matches a 7-bit device address, and ACKs. Write transfers load a register pointer and then write registers; read transfers return registers from the pointer, which auto-increments. It sits between the board I2C pins and the RTC register bank, and does not stretch SCL.

## Interface
- DEV_ADDR, 7'h68, 7-bit target address.
- REG_ADDR_W, 8, register pointer width; the pointer wraps modulo 2^REG_ADDR_W.
- i_clk  in  1  system clock; must be ≥ 20× SCL frequency.
- i_rstn  in  1  reset: synchronous, active-low; clock i_clk.
- i2c_scl  in  1  bus clock, sampled only.
- i2c_sda  inout  1  bus data, open drain: drives 0 or 1'bz.
- o_reg_addr  out  REG_ADDR_W  current register pointer.
- o_reg_wdata  out  8  received write byte.
- o_reg_we  out  1  one-cycle write strobe for o_reg_wdata at o_reg_addr.
- i_reg_rdata  in  8  register contents at o_reg_addr; combinational from the bank.
- o_busy  out  1  high from an address match until STOP.
- o_start  out  1  one-cycle pulse on START or repeated START.
- o_stop  out  1  one-cycle pulse on STOP.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Edge detects are derived from the synchronized values: scl_rise, scl_fall, sda_rise, sda_fall.
- START: sda_fall while SCL is high. Asserts o_start, releases SDA, and enters ADDR from any state.
- STOP: sda_rise while SCL is high. Asserts o_stop, releases SDA, clears o_busy, and enters IDLE from any state.
- Bits are sampled MSB first on scl_rise. SDA is changed only on scl_fall.
- IDLE: SDA released; waits for START.
- ADDR:
  - Shifts in 8 bits.
  - If the address matches DEV_ADDR, sets o_busy and goes to ADDR_ACK.
  - Otherwise goes to IGNORE (SDA released until START or STOP).
  - Address 0 (general call) never matches.
- ADDR_ACK:
  - Drives SDA low from the scl_fall after bit 8 to the scl_fall after the ACK clock.
  - R/W=0 → WR_DATA. The first byte of the transfer is flagged as the pointer byte.
  - R/W=1 → i_reg_rdata is loaded into the shift register at that scl_fall → RD_DATA.
- WR_DATA:
  - Shifts in 8 bits, then enters WR_ACK.
  - Pointer byte: o_reg_addr ← byte[REG_ADDR_W-1:0], with no strobe.
  - Data byte: o_reg_wdata ← byte and o_reg_we is pulsed, both on the cycle after the 8th scl_rise. o_reg_addr increments on the following cycle.
- WR_ACK: drives ACK low as in ADDR_ACK, then returns to WR_DATA.
- RD_DATA: drives the shift register MSB on each scl_fall, 8 bits, then enters RD_ACK. SDA is released at the 8th-bit scl_fall.
- RD_ACK:
  - Samples the controller's ACK on scl_rise and increments o_reg_addr in every case.
  - ACK (0): i_reg_rdata at the new pointer is loaded at scl_fall → RD_DATA.
  - NACK (1): → IGNORE.
- Repeated START keeps o_reg_addr. A pointer write followed by Sr and a read returns data from the written pointer.
- Pointer arithmetic is unsigned modulo 2^REG_ADDR_W; 2^REG_ADDR_W-1 increments to 0.

## Timing
- Reset values:
  - SDA released.
  - State IDLE.
  - o_reg_addr = 0, o_reg_wdata = 0.
  - o_reg_we = 0, o_busy = 0, o_start = 0, o_stop = 0.
- Reset mid-transfer releases SDA on the first reset cycle. No strobe is issued for a partially received byte.
- Pin-to-decision latency is 3 i_clk cycles: 2 synchronizer cycles plus 1 edge-detect cycle. With the filter enabled it is 5 cycles.
- SDA output changes 1 cycle after the detected scl_fall, which gives a data hold time of ≥ 3 i_clk cycles after the SCL pin falls.
- The write strobe is a single cycle, 1 cycle after the 8th scl_rise. The bank must accept the write in that cycle.
- i_reg_rdata is sampled exactly once per read byte, at the launching scl_fall.
- START/STOP detection has priority over bit sampling when it occurs in the same cycle as an SCL edge. An SDA change while SCL is high is always treated as a condition, never as data.
- START in the middle of a byte aborts that byte with no strobe and no pointer change.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN, defined:
  - Each synchronized line passes an additional 3-sample majority filter.
  - Pulses ≤1 i_clk cycle are rejected.
  - Latency increases by 2 cycles.
- Undefined: synchronizer only; a 1-cycle glitch is seen as an edge.

## Test plan
- Write transfer: START, 0xD0, 0x05, 0xAA, 0x55, STOP → three ACKs, then two writes: we@addr 5 with 0xAA and we@addr 6 with 0x55. Final o_reg_addr=7; o_stop pulses.
- Pointer write then read: START, 0xD0, 0x10, Sr, 0xD1, with the bank returning addr+0x80; the controller ACKs twice and NACKs the third byte → SDA carries 0x90, 0x91, 0x92. o_reg_addr=0x13 after the NACK, and SDA is released until STOP.
- Address mismatch: START, 0xA0, 0x00 → SDA is never driven, o_reg_we is never pulsed, and o_busy stays 0.
- Pointer wrap: pointer 0xFF, write 0x11, 0x22 → we@0xFF=0x11 and we@0x00=0x22.
- Reset mid-read: assert i_rstn=0 while the target drives a 0 bit → SDA is z on the next cycle and all outputs are at their reset values.
- Filter build: a 1-cycle SCL low glitch in the middle of a byte → with the macro, no bit is shifted; without the macro, the bit count advances. Both builds are checked.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target port exposing a byte-wide register file, with a 7-bit address match and an auto-incrementing pointer.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
// Ports: i_clk/i_rstn (sync, active-low); i2c_scl in, i2c_sda open-drain inout;
//        o_reg_addr/o_reg_wdata/o_reg_we/i_reg_rdata register bank side;
//        o_busy, o_start, o_stop status.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         REG_ADDR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i2c_scl,
    inout  wire                   i2c_sda,
    output logic [REG_ADDR_W-1:0] o_reg_addr,
    output logic [7:0]            o_reg_wdata,
    output logic                  o_reg_we,
    input  logic [7:0]            i_reg_rdata,
    output logic                  o_busy,
    output logic                  o_start,
    output logic                  o_stop
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl, sda, scl_d, sda_d;
    logic [7:0]  sr;
    logic [3:0]  cnt;
    logic        sda_low, rw, ptr_byte, nack, inc;
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
        end
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_sync[1]};
            sda_h <= {sda_h[1:0], sda_sync[1]};
        end
    end
    assign scl = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif
    wire       scl_rise = scl & ~scl_d;
    wire       scl_fall = ~scl & scl_d;
    wire       start_c  = ~sda & sda_d & scl;
    wire       stop_c   = sda & ~sda_d & scl;
    wire [7:0] nxt      = {sr[6:0], sda};
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= IDLE;
            scl_d       <= 1'b1;
            sda_d       <= 1'b1;
            sr          <= '0;
            cnt         <= '0;
            sda_low     <= 1'b0;
            rw          <= 1'b0;
            ptr_byte    <= 1'b0;
            nack        <= 1'b0;
            inc         <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_reg_we    <= 1'b0;
            o_busy      <= 1'b0;
            o_start     <= 1'b0;
            o_stop      <= 1'b0;
        end else begin
            scl_d    <= scl;
            sda_d    <= sda;
            o_reg_we <= 1'b0;
            o_start  <= 1'b0;
            o_stop   <= 1'b0;
            inc      <= 1'b0;
            // Post-write increment lands the cycle after the strobe so the bank sees a stable address.
            if (inc) o_reg_addr <= o_reg_addr + 1'b1;
            if (start_c) begin
                o_start <= 1'b1;
                sda_low <= 1'b0;
                cnt     <= '0;
                state   <= ADDR;
            end else if (stop_c) begin
                o_stop  <= 1'b1;
                sda_low <= 1'b0;
                o_busy  <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        sr  <= nxt;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            // General call (address 0) is never claimed.
                            if (nxt[7:1] == DEV_ADDR && nxt[7:1] != 7'd0) begin
                                o_busy   <= 1'b1;
                                rw       <= nxt[0];
                                ptr_byte <= 1'b1;
                                state    <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // cnt[0] marks that the ACK is already on the bus; the next fall ends the ACK clock.
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!cnt[0]) begin
                            sda_low <= 1'b1;
                            cnt     <= 4'd1;
                        end else begin
                            cnt <= '0;
                            if (state == WR_ACK || !rw) begin
                                sda_low <= 1'b0;
                                state   <= WR_DATA;
                            end else begin
                                sr      <= i_reg_rdata;
                                sda_low <= ~i_reg_rdata[7];
                                state   <= RD_DATA;
                            end
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        sr  <= nxt;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt      <= '0;
                            ptr_byte <= 1'b0;
                            state    <= WR_ACK;
                            if (ptr_byte) begin
                                o_reg_addr <= REG_ADDR_W'(nxt);
                            end else begin
                                o_reg_wdata <= nxt;
                                o_reg_we    <= 1'b1;
                                inc         <= 1'b1;
                            end
                        end
                    end
                    // sr[7] is the bit on the bus; each fall shifts up the next one until 8 have been clocked.
                    RD_DATA: if (scl_rise) begin
                        cnt <= cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_low <= 1'b0;
                            cnt     <= '0;
                            state   <= RD_ACK;
                        end else begin
                            sr      <= {sr[6:0], 1'b0};
                            sda_low <= ~sr[6];
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        nack       <= sda;
                        cnt        <= 4'd1;
                        o_reg_addr <= o_reg_addr + 1'b1;
                    end else if (scl_fall && cnt[0]) begin
                        cnt <= '0;
                        if (nack) begin
                            state <= IGNORE;
                        end else begin
                            sr      <= i_reg_rdata;
                            sda_low <= ~i_reg_rdata[7];
                            state   <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level bench for i2c_target driving a controller model with a write scoreboard.
module tb_i2c_target;
    localparam int Q = 8;
    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    wire        i2c_sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       we, busy, start, stop;
    int         n_run, n_fail, n_start, n_stop, n_drv;
    logic [15:0] wr_exp[$];
    pullup (i2c_sda);
    assign i2c_sda   = sda_m ? 1'bz : 1'b0;
    assign reg_rdata = reg_addr + 8'h80;
    i2c_target dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i2c_scl    (scl),
        .i2c_sda    (i2c_sda),
        .o_reg_addr (reg_addr),
        .o_reg_wdata(reg_wdata),
        .o_reg_we   (we),
        .i_reg_rdata(reg_rdata),
        .o_busy     (busy),
        .o_start    (start),
        .o_stop     (stop)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (start) n_start++;
            if (stop) n_stop++;
            if (sda_m && i2c_sda === 1'b0) n_drv++;
            if (we) begin
                if (wr_exp.size() == 0) check("we_unexpected", we, 1'b0);
                else check("wr", {reg_addr, reg_wdata}, wr_exp.pop_front());
            end
        end
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    task automatic qw;
        repeat (Q) @(negedge i_clk);
    endtask
    task automatic bus_start;
        sda_m = 1'b1; qw; scl = 1'b1; qw; sda_m = 1'b0; qw; scl = 1'b0; qw;
    endtask
    task automatic bus_stop;
        sda_m = 1'b0; qw; scl = 1'b1; qw; sda_m = 1'b1; qw;
    endtask
    task automatic wbit(input logic b);
        sda_m = b; qw; scl = 1'b1; qw; qw; scl = 1'b0; qw;
    endtask
    task automatic rbit(output logic b);
        sda_m = 1'b1; qw; scl = 1'b1; qw; b = i2c_sda; qw; scl = 1'b0; qw;
    endtask
    // g selects a bit whose high phase gets a 1-cycle SCL low glitch (-1: none).
    task automatic wbyte(input logic [7:0] d, input int g, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; qw; scl = 1'b1; qw;
            if (g == i) begin
                scl = 1'b0;
                @(negedge i_clk);
                scl = 1'b1;
            end
            qw; scl = 1'b0; qw;
        end
        rbit(ack);
    endtask
    task automatic wr(input logic [7:0] d, input string tag);
        logic a;
        wbyte(d, -1, a);
        check(tag, a, 1'b0);
    endtask
    task automatic rbyte(input logic ack_b, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(ack_b);
    endtask
    initial begin
        logic [7:0] d;
        logic       a;
        int         s0, p0, d0;
        repeat (5) @(negedge i_clk);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wdata, 8'h00);
        check("rst_we", we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_stop", stop, 1'b0);
        check("rst_sda", i2c_sda, 1'b1);
        i_rstn = 1'b1;
        qw;
        s0 = n_start;
        p0 = n_stop;
        bus_start;
        wr(8'hD0, "w_addr_ack");
        wr(8'h05, "w_ptr_ack");
        wr_exp.push_back({8'h05, 8'hAA});
        wr(8'hAA, "w_d0_ack");
        wr_exp.push_back({8'h06, 8'h55});
        wr(8'h55, "w_d1_ack");
        check("w_busy", busy, 1'b1);
        bus_stop;
        qw;
        check("w_addr_final", reg_addr, 8'h07);
        check("w_busy_after_stop", busy, 1'b0);
        check("w_start_pulses", n_start - s0, 1);
        check("w_stop_pulses", n_stop - p0, 1);
        check("w_queue_empty", wr_exp.size(), 0);
        bus_start;
        wr(8'hD0, "r_waddr_ack");
        wr(8'h10, "r_ptr_ack");
        bus_start;
        wr(8'hD1, "r_raddr_ack");
        rbyte(1'b0, d);
        check("r_byte0", d, 8'h90);
        rbyte(1'b0, d);
        check("r_byte1", d, 8'h91);
        rbyte(1'b1, d);
        check("r_byte2", d, 8'h92);
        check("r_addr_after_nack", reg_addr, 8'h13);
        d0 = n_drv;
        rbyte(1'b1, d);
        check("r_released_data", d, 8'hFF);
        check("r_released_drv", n_drv - d0, 0);
        bus_stop;
        qw;
        d0 = n_drv;
        bus_start;
        wbyte(8'hA0, -1, a);
        check("m_addr_nack", a, 1'b1);
        check("m_busy0", busy, 1'b0);
        wbyte(8'h00, -1, a);
        check("m_data_nack", a, 1'b1);
        check("m_busy1", busy, 1'b0);
        check("m_no_drive", n_drv - d0, 0);
        bus_stop;
        qw;
        bus_start;
        wr(8'hD0, "p_addr_ack");
        wr(8'hFF, "p_ptr_ack");
        wr_exp.push_back({8'hFF, 8'h11});
        wr(8'h11, "p_d0_ack");
        wr_exp.push_back({8'h00, 8'h22});
        wr(8'h22, "p_d1_ack");
        bus_stop;
        qw;
        check("p_addr_final", reg_addr, 8'h01);
        check("p_queue_empty", wr_exp.size(), 0);
        bus_start;
        wr(8'hD0, "x_waddr_ack");
        wr(8'h01, "x_ptr_ack");
        bus_start;
        wr(8'hD1, "x_raddr_ack");
        rbit(a);
        check("x_bit7", a, 1'b1);
        check("x_drive0", i2c_sda, 1'b0);
        i_rstn = 1'b0;
        @(negedge i_clk);
        check("x_rst_sda", i2c_sda, 1'b1);
        check("x_rst_addr", reg_addr, 8'h00);
        check("x_rst_busy", busy, 1'b0);
        check("x_rst_we", we, 1'b0);
        check("x_rst_start", start, 1'b0);
        check("x_rst_stop", stop, 1'b0);
        i_rstn = 1'b1;
        bus_stop;
        qw;
        bus_start;
        wr(8'hD0, "g_addr_ack");
        wr(8'h20, "g_ptr_ack");
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        wr_exp.push_back({8'h20, 8'h3C});
        wbyte(8'h3C, 7, a);
        check("g_ack", a, 1'b0);
`else
        wr_exp.push_back({8'h20, 8'h1E});
        wbyte(8'h3C, 7, a);
        check("g_ack", a, 1'b1);
`endif
        bus_stop;
        qw;
        check("g_addr_final", reg_addr, 8'h21);
        check("g_queue_empty", wr_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
